regfile_writeback_arbiter: RTL

// Drives the single write port of register_file (RegWrite/rd/write_data). Merges

---
 rtl/regfile_writeback_arbiter_if.sv | 29 ++
 rtl/regfile_writeback_arbiter.sv | 132 +++++++++++++
 2 files changed

// File: rtl/regfile_writeback_arbiter_if.sv
// Write-back bus between the ALU/load sources and the register-file write port.
// master: source side (drives alu_*/mem_* requests, observes stall/ready/write port).
// slave : arbiter side (consumes requests, drives stall/ready/pending mask/write port).
interface regfile_writeback_arbiter_if;
  logic        alu_valid;
  logic [4:0]  alu_rd;
  logic [31:0] alu_data;
  logic        alu_stall;
  logic        mem_valid;
  logic        mem_ready;
  logic [4:0]  mem_rd;
  logic [2:0]  mem_funct3;
  logic [1:0]  mem_addr_lo;
  logic [31:0] mem_data;
  logic [31:0] pending_mask;
  logic        RegWrite;
  logic [4:0]  rd;
  logic [31:0] write_data;

  modport master (
    output alu_valid, alu_rd, alu_data, mem_valid, mem_rd, mem_funct3, mem_addr_lo, mem_data,
    input  alu_stall, mem_ready, pending_mask, RegWrite, rd, write_data
  );

  modport slave (
    input  alu_valid, alu_rd, alu_data, mem_valid, mem_rd, mem_funct3, mem_addr_lo, mem_data,
    output alu_stall, mem_ready, pending_mask, RegWrite, rd, write_data
  );
endinterface

// File: rtl/regfile_writeback_arbiter.sv
// Drives the register-file write port, merging single-cycle ALU results with
// buffered, already-extended load results. ALU has priority until a load has
// waited STARVE_LIMIT ALU wins, then the ALU is stalled for one cycle.
// Ports: clk, rst (sync, active-high); bus (slave modport): alu_* request with
// alu_stall, mem_* load handshake with mem_ready, pending_mask, RegWrite/rd/write_data.
module regfile_writeback_arbiter #(
  parameter int unsigned DEPTH        = 2,
  parameter int unsigned STARVE_LIMIT = 4
) (
  input logic                        clk,
  input logic                        rst,
  regfile_writeback_arbiter_if.slave bus
);
  localparam int unsigned PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned CW = PW + 1;
  localparam int unsigned SW = $clog2(STARVE_LIMIT + 1);

  logic [4:0]    fifo_rd_q   [DEPTH];
  logic [31:0]   fifo_data_q [DEPTH];
  logic [PW-1:0] head_q, head_d, tail_q, tail_d;
  logic [CW-1:0] count_q, count_d;
  logic [SW-1:0] starve_q, starve_d;
  logic          we_q, we_d;
  logic [4:0]    rd_q, rd_d;
  logic [31:0]   wd_q, wd_d;

  logic          fifo_empty, alu_req, stall_c, ready_c, push, pop;
  logic [31:0]   load_val;
  logic [31:0]   mask_c;
  logic [PW-1:0] off;

  // Byte/half select by address, then sign or zero extend by load type.
  function automatic logic [31:0] load_extend(input logic [2:0] f3, input logic [1:0] lo,
                                              input logic [31:0] w);
    logic [7:0]  b;
    logic [15:0] h;
    b = 8'(w >> {lo, 3'b000});
    h = 16'(w >> {lo[1], 4'b0000});
    case (f3)
      3'b000:  return {{24{b[7]}}, b};
      3'b001:  return {{16{h[15]}}, h};
      3'b100:  return {24'd0, b};
      3'b101:  return {16'd0, h};
      default: return w;
    endcase
  endfunction

  assign fifo_empty = (count_q == '0);
  assign alu_req    = bus.alu_valid && (bus.alu_rd != 5'd0);
  assign stall_c    = !rst && !fifo_empty && (starve_q == SW'(STARVE_LIMIT));
  assign ready_c    = !rst && (count_q < CW'(DEPTH));
  // rd==0 loads complete the handshake but are never stored.
  assign push       = bus.mem_valid && ready_c && (bus.mem_rd != 5'd0);
  assign load_val   = load_extend(bus.mem_funct3, bus.mem_addr_lo, bus.mem_data);

  // Arbitration and next-state
  always_comb begin
    we_d     = 1'b0;
    rd_d     = rd_q;
    wd_d     = wd_q;
    pop      = 1'b0;
    starve_d = starve_q;
    if (stall_c) begin
      pop = 1'b1;
    end else if (alu_req) begin
      we_d = 1'b1;
      rd_d = bus.alu_rd;
      wd_d = bus.alu_data;
    end else if (!fifo_empty) begin
      pop = 1'b1;
    end
    if (pop) begin
      we_d = 1'b1;
      rd_d = fifo_rd_q[head_q];
      wd_d = fifo_data_q[head_q];
    end
    if (pop || fifo_empty) begin
      starve_d = '0;
    end else if (alu_req && (starve_q != SW'(STARVE_LIMIT))) begin
      starve_d = starve_q + SW'(1);
    end
    head_d  = pop  ? head_q + PW'(1) : head_q;
    tail_d  = push ? tail_q + PW'(1) : tail_q;
    count_d = count_q + CW'(push) - CW'(pop);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      head_q   <= '0;
      tail_q   <= '0;
      count_q  <= '0;
      starve_q <= '0;
      we_q     <= 1'b0;
      rd_q     <= 5'd0;
      wd_q     <= 32'd0;
    end else begin
      head_q   <= head_d;
      tail_q   <= tail_d;
      count_q  <= count_d;
      starve_q <= starve_d;
      we_q     <= we_d;
      rd_q     <= rd_d;
      wd_q     <= wd_d;
    end
  end

  // Entry storage; validity is tracked by head/count, so no reset needed.
  always_ff @(posedge clk) begin
    if (push) begin
      fifo_rd_q[tail_q]   <= bus.mem_rd;
      fifo_data_q[tail_q] <= load_val;
    end
  end

  // Entry i is live when its distance from head is below count.
  always_comb begin
    mask_c = 32'd0;
    off    = '0;
    for (int unsigned i = 0; i < DEPTH; i++) begin
      off = PW'(i) - head_q;
      if (CW'(off) < count_q) mask_c[fifo_rd_q[PW'(i)]] = 1'b1;
    end
    mask_c[0] = 1'b0;
  end

  assign bus.alu_stall    = stall_c;
  assign bus.mem_ready    = ready_c;
  assign bus.pending_mask = mask_c;
  assign bus.RegWrite     = we_q;
  assign bus.rd           = rd_q;
  assign bus.write_data   = wd_q;
endmodule
